// File: rtl/tl_rx_rcv_overflow_tracker.sv
// CREDITS_RECEIVED bookkeeping for the TL RX path: per-channel header/data counters,
// receiver-overflow check against CREDITS_ALLOCATED, and error pulse/sticky/count reporting.
module tl_rx_rcv_overflow_tracker #(
  parameter int N_CH            = 3,
  parameter int CH_W            = 2,
  parameter int PAYLOAD_LENGTH  = 10,
  parameter int HDR_FIELD_SIZE  = 8,
  parameter int DATA_FIELD_SIZE = 12,
  parameter int ERR_CNT_W       = 8
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_credit_init,
  input  logic                              i_tlp_valid,
  input  logic [CH_W-1:0]                   i_tlp_ch,
  input  logic                              i_tlp_has_data,
  input  logic [PAYLOAD_LENGTH-1:0]         i_tlp_len,
  input  logic [N_CH*HDR_FIELD_SIZE-1:0]    i_alloc_hdr,
  input  logic [N_CH*DATA_FIELD_SIZE-1:0]   i_alloc_data,
  input  logic [N_CH-1:0]                   i_inf_hdr,
  input  logic [N_CH-1:0]                   i_inf_data,
  input  logic [N_CH-1:0]                   i_err_clr,
  output logic [N_CH*HDR_FIELD_SIZE-1:0]    o_rcv_hdr,
  output logic [N_CH*DATA_FIELD_SIZE-1:0]   o_rcv_data,
  output logic                              o_overflow_err,
  output logic [CH_W-1:0]                   o_overflow_ch,
  output logic [N_CH-1:0]                   o_err_sticky,
  output logic [ERR_CNT_W-1:0]              o_err_cnt
);

  localparam int H     = HDR_FIELD_SIZE;
  localparam int D     = DATA_FIELD_SIZE;
  localparam int LEN_W = PAYLOAD_LENGTH + 2;

  logic [H-1:0] rcv_hdr_q  [N_CH];
  logic [D-1:0] rcv_data_q [N_CH];

  logic             ch_ok;
  logic [H-1:0]     sel_alloc_hdr, sel_rcv_hdr, hdr_diff;
  logic [D-1:0]     sel_alloc_data, sel_rcv_data, data_diff;
  logic             sel_inf_hdr, sel_inf_data;
  logic [LEN_W-1:0] len_eff, nd_raw;
  logic [D-1:0]     nd;
  logic             hdr_ovf, data_ovf;
  logic             accept, ovf_ev, clean_ev;
  logic [N_CH-1:0]  err_set;

  always_comb begin
    ch_ok          = 1'b0;
    sel_alloc_hdr  = '0;
    sel_alloc_data = '0;
    sel_rcv_hdr    = '0;
    sel_rcv_data   = '0;
    sel_inf_hdr    = 1'b0;
    sel_inf_data   = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (i_tlp_ch == CH_W'(c)) begin
        ch_ok          = 1'b1;
        sel_alloc_hdr  = i_alloc_hdr[c*H +: H];
        sel_alloc_data = i_alloc_data[c*D +: D];
        sel_rcv_hdr    = rcv_hdr_q[c];
        sel_rcv_data   = rcv_data_q[c];
        sel_inf_hdr    = i_inf_hdr[c];
        sel_inf_data   = i_inf_data[c];
      end
    end
  end

  // Length 0 means the maximum payload, 2^PAYLOAD_LENGTH DW; one data credit covers 4 DW.
  always_comb begin
    len_eff = (i_tlp_len == '0) ? (LEN_W'(1) << PAYLOAD_LENGTH) : LEN_W'(i_tlp_len);
    nd_raw  = (len_eff + LEN_W'(3)) >> 2;
    nd      = i_tlp_has_data ? D'(nd_raw) : '0;
  end

  // Modular headroom check: a negative remainder (MSB set) means the sender overran its grant.
  assign hdr_diff  = sel_alloc_hdr - (sel_rcv_hdr + H'(1));
  assign data_diff = sel_alloc_data - (sel_rcv_data + nd);
  assign hdr_ovf   = !sel_inf_hdr && hdr_diff[H-1];
  assign data_ovf  = i_tlp_has_data && !sel_inf_data && data_diff[D-1];

  assign accept   = i_tlp_valid && !i_credit_init && ch_ok;
  assign ovf_ev   = accept && (hdr_ovf || data_ovf);
  assign clean_ev = accept && !(hdr_ovf || data_ovf);
  assign err_set  = ovf_ev ? (N_CH'(1) << i_tlp_ch) : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < N_CH; c++) begin
        rcv_hdr_q[c]  <= '0;
        rcv_data_q[c] <= '0;
      end
      o_overflow_err <= 1'b0;
      o_overflow_ch  <= '0;
      o_err_sticky   <= '0;
      o_err_cnt      <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (i_credit_init) begin
          rcv_hdr_q[c]  <= '0;
          rcv_data_q[c] <= '0;
        end else if (clean_ev && (i_tlp_ch == CH_W'(c))) begin
          rcv_hdr_q[c]  <= rcv_hdr_q[c] + H'(1);
          rcv_data_q[c] <= rcv_data_q[c] + nd;
        end
      end
      o_overflow_err <= ovf_ev;
      if (ovf_ev) begin
        o_overflow_ch <= i_tlp_ch;
        if (o_err_cnt != '1)
          o_err_cnt <= o_err_cnt + ERR_CNT_W'(1);
      end
      o_err_sticky <= (o_err_sticky & ~i_err_clr) | err_set;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_pack
    assign o_rcv_hdr[g*H +: H]  = rcv_hdr_q[g];
    assign o_rcv_data[g*D +: D] = rcv_data_q[g];
  end

endmodule

// File: tb/tb_tl_rx_rcv_overflow_tracker.sv
// Scoreboard bench for tl_rx_rcv_overflow_tracker: each driven cycle pushes the expected
// post-edge state from a reference model; a monitor pops and compares one cycle later.
module tb_tl_rx_rcv_overflow_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        credit_init, tlp_valid, tlp_has_data;
  logic [1:0]  tlp_ch;
  logic [9:0]  tlp_len;
  logic [7:0]  a_hdr  [3];
  logic [11:0] a_data [3];
  logic [23:0] alloc_hdr;
  logic [35:0] alloc_data;
  logic [2:0]  inf_hdr, inf_data, err_clr;
  logic [23:0] rcv_hdr;
  logic [35:0] rcv_data;
  logic        overflow_err;
  logic [1:0]  overflow_ch;
  logic [2:0]  err_sticky;
  logic [7:0]  err_cnt;

  assign alloc_hdr  = {a_hdr[2], a_hdr[1], a_hdr[0]};
  assign alloc_data = {a_data[2], a_data[1], a_data[0]};

  always #5 clk = ~clk;

  tl_rx_rcv_overflow_tracker dut (
    .i_clk(clk), .i_rst(rst), .i_credit_init(credit_init), .i_tlp_valid(tlp_valid),
    .i_tlp_ch(tlp_ch), .i_tlp_has_data(tlp_has_data), .i_tlp_len(tlp_len),
    .i_alloc_hdr(alloc_hdr), .i_alloc_data(alloc_data), .i_inf_hdr(inf_hdr),
    .i_inf_data(inf_data), .i_err_clr(err_clr), .o_rcv_hdr(rcv_hdr), .o_rcv_data(rcv_data),
    .o_overflow_err(overflow_err), .o_overflow_ch(overflow_ch), .o_err_sticky(err_sticky),
    .o_err_cnt(err_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [23:0] hdr;
    logic [35:0] data;
    logic        err;
    logic [1:0]  ch;
    logic [2:0]  sticky;
    logic [7:0]  cnt;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0]  m_hdr  [3];
  logic [11:0] m_data [3];
  logic [1:0]  m_ch;
  logic [2:0]  m_sticky;
  logic [7:0]  m_cnt;

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_hdr[c] = '0;
      m_data[c] = '0;
    end
    m_ch = '0; m_sticky = '0; m_cnt = '0;
  endtask

  task automatic step(input logic v, input int ch, input logic hd, input int len,
                      input logic init = 1'b0, input logic [2:0] clr = 3'b000);
    int nd, lw;
    logic hovf, dovf, ovf;
    logic [2:0] set;
    exp_t e;
    @(negedge clk);
    tlp_valid = v; tlp_ch = 2'(ch); tlp_has_data = hd; tlp_len = 10'(len);
    credit_init = init; err_clr = clr;
    lw  = (len == 0) ? 1024 : len;
    nd  = hd ? (lw + 3) / 4 : 0;
    ovf = 1'b0;
    set = '0;
    if (v && !init && ch < 3) begin
      hovf = !inf_hdr[ch] && ((((int'(a_hdr[ch]) - int'(m_hdr[ch]) - 1) & 'hFF)) >= 128);
      dovf = hd && !inf_data[ch] && ((((int'(a_data[ch]) - int'(m_data[ch]) - nd) & 'hFFF)) >= 2048);
      ovf  = hovf || dovf;
      if (ovf) begin
        set[ch] = 1'b1;
        m_ch = 2'(ch);
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end else begin
        m_hdr[ch]  = m_hdr[ch] + 8'd1;
        m_data[ch] = m_data[ch] + 12'(nd);
      end
    end
    if (init) begin
      for (int c = 0; c < 3; c++) begin
        m_hdr[c] = '0;
        m_data[c] = '0;
      end
    end
    m_sticky = (m_sticky & ~clr) | set;
    e.hdr = {m_hdr[2], m_hdr[1], m_hdr[0]};
    e.data = {m_data[2], m_data[1], m_data[0]};
    e.err = ovf; e.ch = m_ch; e.sticky = m_sticky; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [2:0] clr = 3'b000);
    step(1'b0, 0, 1'b0, 0, 1'b0, clr);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("rcv_hdr", 64'(rcv_hdr), 64'(e.hdr));
      chk("rcv_data", 64'(rcv_data), 64'(e.data));
      chk("ovf_err", 64'(overflow_err), 64'(e.err));
      chk("ovf_ch", 64'(overflow_ch), 64'(e.ch));
      chk("sticky", 64'(err_sticky), 64'(e.sticky));
      chk("err_cnt", 64'(err_cnt), 64'(e.cnt));
    end
  end

  initial begin
    rst = 1'b1; credit_init = 1'b0; tlp_valid = 1'b0; tlp_ch = '0; tlp_has_data = 1'b0;
    tlp_len = '0; inf_hdr = '0; inf_data = '0; err_clr = '0;
    for (int c = 0; c < 3; c++) begin
      a_hdr[c] = '0;
      a_data[c] = '0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_hdr", 64'(rcv_hdr), 64'd0);
    chk("rst_cnt", 64'(err_cnt), 64'd0);
    rst = 1'b0;
    idle();

    // Posted: 4 header credits, fifth TLP overflows
    a_hdr[0] = 8'd4; a_data[0] = 12'h100;
    for (int i = 0; i < 5; i++) step(1'b1, 0, 1'b0, 0);
    idle();
    chk("p_hdr", 64'(rcv_hdr[7:0]), 64'd4);
    chk("p_err", 64'(overflow_err), 64'd1);
    chk("p_sticky", 64'(err_sticky[0]), 64'd1);
    chk("p_cnt", 64'(err_cnt), 64'd1);

    // Non-posted data credits
    a_hdr[1] = 8'h10; a_data[1] = 12'd8;
    step(1'b1, 1, 1'b1, 32);
    step(1'b1, 1, 1'b1, 1);
    idle();
    chk("np_data", 64'(rcv_data[23:12]), 64'd8);
    chk("np_ch", 64'(overflow_ch), 64'd1);

    // Completion, length 0 = 1024 DW = 256 credits
    a_hdr[2] = 8'h10; a_data[2] = 12'h100;
    step(1'b1, 2, 1'b1, 0);
    step(1'b1, 2, 1'b1, 3);
    idle();
    chk("cpl_data", 64'(rcv_data[35:24]), 64'h100);
    chk("cpl_ch", 64'(overflow_ch), 64'd2);

    // Header counter wrap on P; allocation advanced only while the pipe is idle
    step(1'b0, 0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 255; i++) begin
      if (i % 64 == 0) begin
        idle();
        a_hdr[0] = 8'(i + 100);
      end
      step(1'b1, 0, 1'b0, 0);
    end
    idle();
    chk("wrap_pre", 64'(rcv_hdr[7:0]), 64'hFF);
    a_hdr[0] = 8'h05;
    step(1'b1, 0, 1'b0, 0);
    idle();
    chk("wrap_hdr", 64'(rcv_hdr[7:0]), 64'h00);
    chk("wrap_err", 64'(overflow_err), 64'd0);

    // Infinite credits still count
    step(1'b0, 0, 1'b0, 0, 1'b1);
    idle();
    inf_hdr[0] = 1'b1; inf_data[0] = 1'b1; a_hdr[0] = '0; a_data[0] = '0;
    for (int i = 0; i < 300; i++) step(1'b1, 0, 1'b1, 4);
    idle();
    chk("inf_hdr", 64'(rcv_hdr[7:0]), 64'd44);
    chk("inf_data", 64'(rcv_data[11:0]), 64'd300);

    // Out-of-range channel ignored
    step(1'b1, 3, 1'b1, 8);
    idle();
    chk("oor_err", 64'(overflow_err), 64'd0);

    // credit_init beats a concurrent TLP
    step(1'b1, 0, 1'b1, 4, 1'b1);
    idle();
    chk("init_hdr", 64'(rcv_hdr), 64'd0);
    chk("init_data", 64'(rcv_data), 64'd0);
    chk("init_err", 64'(overflow_err), 64'd0);

    // Set beats a concurrent clear, then a plain clear works
    inf_hdr = '0; inf_data = '0;
    step(1'b1, 0, 1'b0, 0, 1'b0, 3'b001);
    idle();
    chk("clr_race", 64'(err_sticky[0]), 64'd1);
    idle(3'b001);
    idle();
    chk("clr_done", 64'(err_sticky), 64'b110);

    // Error counter saturates
    for (int i = 0; i < 260; i++) step(1'b1, 0, 1'b0, 0);
    idle();
    chk("cnt_sat", 64'(err_cnt), 64'hFF);

    // Asynchronous reset mid-stream
    a_hdr[1] = 8'h10;
    step(1'b1, 1, 1'b0, 0);
    idle();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_hdr", 64'(rcv_hdr), 64'd0);
    chk("arst_sticky", 64'(err_sticky), 64'd0);
    chk("arst_cnt", 64'(err_cnt), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1, 1'b0, 0);
    idle();
    chk("post_rst", 64'(rcv_hdr[15:8]), 64'd1);

    @(negedge clk);
    @(negedge clk);
    chk("q_drain", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
